// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN layer sequencer and its datapath.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT
  } acc_state_t;

  // Accumulator width that holds the sum of NUM_INPUTS signed weights without overflow
  function automatic int acc_width(input int data_w, input int num_inputs);
    return data_w + $clog2(num_inputs) + 1;
  endfunction

endpackage

// File: rtl/snn_sat.sv
// Combinational clamp of a wide signed sum onto the narrow signed result range.
// Optional feature macro: SNN_ACC_RELU_EN (negative sums forced to zero).
module snn_sat #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(2 ** (OUT_W - 1)));

  // Clamp to the representable output range, then optionally rectify
  always_comb begin
    if (din > SAT_MAX) begin
      dout = SAT_MAX[OUT_W-1:0];
    end else if (din < SAT_MIN) begin
      dout = SAT_MIN[OUT_W-1:0];
    end else begin
      dout = din[OUT_W-1:0];
    end
`ifdef SNN_ACC_RELU_EN
    if (din[IN_W-1]) begin
      dout = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/snn_neuron_accum.sv
// Weighted-sum engine for one fully-connected SNN layer. Walks every (neuron, input)
// pair against an external registered weight ROM and emits one saturated sum per neuron.
// Optional feature macro: SNN_ACC_RELU_EN (applied inside snn_sat on the result path).
module snn_neuron_accum
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 32,
  parameter int NUM_NEURONS = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_INPUTS-1:0]          in_spikes,
  output logic [ADDR_WIDTH-1:0]          rom_addr,
  input  logic [DATA_WIDTH-1:0]          rom_q,
  output logic                           res_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] res_idx,
  output logic [OUT_WIDTH-1:0]           res_data,
  output logic                           busy,
  output logic                           done
);

  localparam int IW    = $clog2(NUM_INPUTS);
  localparam int NW    = $clog2(NUM_NEURONS);
  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_INPUTS);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

  if (NUM_INPUTS * NUM_NEURONS > 2 ** ADDR_WIDTH) begin : g_addr_check
    $error("snn_neuron_accum: ROM address space too small for NUM_INPUTS*NUM_NEURONS");
  end

  acc_state_t               state_q, state_d;
  logic [NW-1:0]            n_q, n_d;
  logic [IW-1:0]            i_q, i_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [NUM_INPUTS-1:0]    spk_q, spk_d;
  logic                     p_vld_q, p_vld_d;
  logic                     p_spk_q, p_spk_d;
  logic [ADDR_WIDTH-1:0]    rom_addr_q, rom_addr_d;
  logic                     res_valid_q, res_valid_d;
  logic [NW-1:0]            res_idx_q, res_idx_d;
  logic [OUT_WIDTH-1:0]     res_data_q, res_data_d;
  logic                     done_q, done_d;

  logic signed [ACC_W-1:0]  rom_ext;
  logic signed [OUT_WIDTH-1:0] sat_acc;

  assign rom_ext = {{(ACC_W - DATA_WIDTH){rom_q[DATA_WIDTH-1]}}, rom_q};

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [NW-1:0] n,
                                                    input logic [IW-1:0] i);
    return ADDR_WIDTH'(n) * ADDR_WIDTH'(NUM_INPUTS) + ADDR_WIDTH'(i);
  endfunction

  snn_sat #(
    .IN_W (ACC_W),
    .OUT_W(OUT_WIDTH)
  ) u_sat (
    .din (acc_q),
    .dout(sat_acc)
  );

  // Sequencer next-state: the p_* flags delay the spike bit by one edge so it meets its ROM word
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    i_d         = i_q;
    spk_d       = spk_q;
    rom_addr_d  = rom_addr_q;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    p_vld_d     = 1'b0;
    p_spk_d     = 1'b0;
    done_d      = res_valid_q && (res_idx_q == N_LAST);
    acc_d       = acc_q + ((p_vld_q && p_spk_q) ? rom_ext : '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          spk_d      = in_spikes;
          n_d        = '0;
          i_d        = '0;
          acc_d      = '0;
          rom_addr_d = '0;
        end
      end
      FETCH: begin
        p_vld_d = 1'b1;
        p_spk_d = spk_q[i_q];
        i_d     = i_q + IW'(1);
        if (i_q == I_LAST) begin
          state_d = DRAIN;
        end else begin
          rom_addr_d = addr_of(n_q, i_q + IW'(1));
        end
      end
      DRAIN: begin
        state_d = EMIT;
      end
      EMIT: begin
        res_valid_d = 1'b1;
        res_idx_d   = n_q;
        res_data_d  = sat_acc;
        acc_d       = '0;
        i_d         = '0;
        if (n_q == N_LAST) begin
          state_d = IDLE;
        end else begin
          state_d    = FETCH;
          n_d        = n_q + NW'(1);
          rom_addr_d = addr_of(n_q + NW'(1), IW'(0));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      i_q         <= '0;
      acc_q       <= '0;
      spk_q       <= '0;
      p_vld_q     <= 1'b0;
      p_spk_q     <= 1'b0;
      rom_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      i_q         <= i_d;
      acc_q       <= acc_d;
      spk_q       <= spk_d;
      p_vld_q     <= p_vld_d;
      p_spk_q     <= p_spk_d;
      rom_addr_q  <= rom_addr_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_snn_neuron_accum.sv
// Randomised self-checking bench for snn_neuron_accum with a behavioural weight ROM.
// Honours SNN_ACC_RELU_EN in its reference model.
module tb_snn_neuron_accum;

  localparam int NI = 32;
  localparam int NN = 32;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int OW = 8;
  localparam int PER_NEURON = NI + 2;
  localparam int DONE_CYCLE = NN * PER_NEURON + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NI-1:0] in_spikes;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          res_valid;
  logic [4:0]    res_idx;
  logic [OW-1:0] res_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NI*NN];

  int checkCount = 0;
  int failCount  = 0;

  // 50 MHz clock
  always #10 clk = ~clk;

  // Registered weight ROM with one-cycle read latency
  always @(posedge clk) rom_q <= mem[rom_addr];

  snn_neuron_accum #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_spikes(in_spikes),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .res_valid(res_valid),
    .res_idx  (res_idx),
    .res_data (res_data),
    .busy     (busy),
    .done     (done)
  );

  // Reference result for one neuron: plain signed sum of spiking weights, then clamp
  function automatic int refResult(input int n, input logic [NI-1:0] spk);
    int sum;
    sum = 0;
    for (int i = 0; i < NI; i++) begin
      if (spk[i]) sum += int'($signed(mem[n*NI+i]));
    end
    if (sum > 127) sum = 127;
    if (sum < -128) sum = -128;
`ifdef SNN_ACC_RELU_EN
    if (sum < 0) sum = 0;
`else
`endif
    return sum;
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic fillMem(input logic [DW-1:0] value);
    for (int a = 0; a < NI*NN; a++) mem[a] = value;
  endtask

  // One layer pass: optional start glitch at cycle 5, optional reset abort, optional
  // back-to-back exit on the done cycle so the next pass starts without a gap
  task automatic applyStimulus(input logic [NI-1:0] spk, input bit glitch,
                               input int abortAt, input bit backToBack);
    int  expectedRes[NN];
    int  resCount;
    int  extraEvents;
    int  expAddr;
    bit  doneSeen;
    resCount    = 0;
    extraEvents = 0;
    doneSeen    = 1'b0;
    for (int n = 0; n < NN; n++) expectedRes[n] = refResult(n, spk);
    in_spikes = spk;
    start     = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      start     = 1'b0;
      in_spikes = $urandom;
      if (abortAt >= 0 && c == abortAt + 1) begin
        rst = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
      end
      if (c == 0) checkOutput("busy_at_start", int'(busy), 1);
      if (abortAt < 0 && (c <= 1 || (c >= 31 && c <= 35))) begin
        expAddr = (c < 32) ? c : ((c < 34) ? 31 : c - 2);
        checkOutput("rom_addr", int'(rom_addr), expAddr);
      end
      if (res_valid) begin
        if (abortAt >= 0 && c > abortAt) begin
          extraEvents++;
        end else begin
          checkOutput("res_idx", int'(res_idx), resCount);
          checkOutput("res_cycle", c, (resCount + 1) * PER_NEURON);
          checkOutput("res_data", int'($signed(res_data)),
                      (resCount < NN) ? expectedRes[resCount] : 9999);
          resCount++;
        end
      end
      if (done) begin
        if (abortAt >= 0) begin
          extraEvents++;
        end else begin
          checkOutput("done_cycle", c, DONE_CYCLE);
          checkOutput("res_count", resCount, NN);
          checkOutput("busy_at_done", int'(busy), 0);
          doneSeen = 1'b1;
          break;
        end
      end
      if (glitch && c == 5) start = 1'b1;
      if (abortAt >= 0 && c == abortAt) rst = 1'b1;
      if (abortAt >= 0 && c == abortAt + 150) break;
    end
    if (abortAt >= 0) begin
      checkOutput("abort_events", extraEvents, 0);
    end else if (!doneSeen) begin
      checkOutput("done_timeout", 0, 1);
    end
    if (!backToBack) repeat (2) @(negedge clk);
  endtask

  // Test sequence
  initial begin
    logic [NI-1:0] spk;
    rst       = 1'b1;
    start     = 1'b1;
    in_spikes = '1;
    fillMem(8'h00);
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(res_valid), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_addr", int'(rom_addr), 0);
    checkOutput("reset_idx", int'(res_idx), 0);
    checkOutput("reset_data", int'(res_data), 0);

    $display("[TB] unit weights, all spikes");
    fillMem(8'h01);
    applyStimulus('1, 1'b0, -1, 1'b0);

    $display("[TB] alignment: spike 0 only");
    fillMem(8'h55);
    for (int n = 0; n < NN; n++) mem[n*NI] = DW'(n);
    applyStimulus(32'h0000_0001, 1'b0, -1, 1'b0);

    $display("[TB] positive saturation");
    fillMem(8'h7F);
    applyStimulus('1, 1'b0, -1, 1'b0);

    $display("[TB] negative saturation");
    fillMem(8'h80);
    applyStimulus('1, 1'b0, -1, 1'b0);

    $display("[TB] start while busy, reset abort, fresh pass");
    fillMem(8'h01);
    applyStimulus('1, 1'b1, -1, 1'b0);
    applyStimulus('1, 1'b0, 10, 1'b0);
    applyStimulus('1, 1'b0, -1, 1'b0);

    $display("[TB] no spikes, then back-to-back start");
    applyStimulus('0, 1'b0, -1, 1'b1);
    applyStimulus('1, 1'b0, -1, 1'b0);

    $display("[TB] random weights and spikes");
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < NI*NN; a++) mem[a] = DW'($urandom);
      spk = $urandom;
      applyStimulus(spk, 1'b0, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
